// File: rtl/do_debounce.sv
// Debounces a raw request line into the registered "do" level (do_out), with edge strobes and a
// saturating glitch counter. Define DO_DEBOUNCE_SYNC_EN to add a two-flop input synchroniser.
module do_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned GLITCH_W        = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                raw_in,
   output logic                do_out,
   output logic                do_rise,
   output logic                do_fall,
   output logic [GLITCH_W-1:0] glitch_cnt
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_LOW      = 2'd0,
      ST_RISE_CHK = 2'd1,
      ST_HIGH     = 2'd2,
      ST_FALL_CHK = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                do_q, do_d;
   logic                rise_q, rise_d;
   logic                fall_q, fall_d;
   logic [GLITCH_W-1:0] glitch_q, glitch_d;
   logic [GLITCH_W-1:0] glitch_sat;
   logic                cnt_done;
   logic                s_in;

`ifdef DO_DEBOUNCE_SYNC_EN
   logic [1:0] sync_q, sync_d;

   always_comb begin
      sync_d = {sync_q[0], raw_in};
   end

   assign s_in = sync_q[1];
`else
   assign s_in = raw_in;
`endif

   assign cnt_done   = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
   assign glitch_sat = (glitch_q == {GLITCH_W{1'b1}}) ? glitch_q : glitch_q + GLITCH_W'(1);

   // Next-state: any opposite sample during a check aborts it and restarts from zero.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      do_d     = do_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      glitch_d = glitch_q;
      unique case (state_q)
         ST_LOW: begin
            if (s_in) begin
               state_d = ST_RISE_CHK;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_RISE_CHK: begin
            if (!s_in) begin
               state_d  = ST_LOW;
               cnt_d    = '0;
               glitch_d = glitch_sat;
            end else if (cnt_done) begin
               state_d = ST_HIGH;
               do_d    = 1'b1;
               rise_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HIGH: begin
            if (!s_in) begin
               state_d = ST_FALL_CHK;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_FALL_CHK: begin
            if (s_in) begin
               state_d  = ST_HIGH;
               cnt_d    = '0;
               glitch_d = glitch_sat;
            end else if (cnt_done) begin
               state_d = ST_LOW;
               do_d    = 1'b0;
               fall_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_LOW;
            cnt_d   = '0;
            do_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_LOW;
         cnt_q    <= '0;
         do_q     <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         glitch_q <= '0;
`ifdef DO_DEBOUNCE_SYNC_EN
         sync_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         do_q     <= do_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         glitch_q <= glitch_d;
`ifdef DO_DEBOUNCE_SYNC_EN
         sync_q   <= sync_d;
`endif
      end
   end

   assign do_out     = do_q;
   assign do_rise    = rise_q;
   assign do_fall    = fall_q;
   assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_do_debounce.sv
// Directed self-checking bench for do_debounce; a second instance with GLITCH_W=2 covers saturation.
module tb_do_debounce;

`ifdef DO_DEBOUNCE_SYNC_EN
   localparam int LAT = 6;
`else
   localparam int LAT = 4;
`endif

   logic       clk;
   logic       rst;
   logic       raw_in;
   logic       do_out, do_rise, do_fall;
   logic [7:0] glitch_cnt;
   logic       sat_do, sat_rise, sat_fall;
   logic [1:0] sat_glitch;

   int checks;
   int errors;

   do_debounce #(.DEBOUNCE_CYCLES(4), .GLITCH_W(8)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .raw_in    (raw_in),
      .do_out    (do_out),
      .do_rise   (do_rise),
      .do_fall   (do_fall),
      .glitch_cnt(glitch_cnt)
   );

   do_debounce #(.DEBOUNCE_CYCLES(4), .GLITCH_W(2)) u_sat (
      .clk       (clk),
      .rst       (rst),
      .raw_in    (raw_in),
      .do_out    (sat_do),
      .do_rise   (sat_rise),
      .do_fall   (sat_fall),
      .glitch_cnt(sat_glitch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      raw_in = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      raw_in = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if ({do_out, do_rise, do_fall} !== 3'b000 || glitch_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_hold cyc%0d got do/r/f=%b%b%b glitch=%0d exp 000 glitch=0",
                     k, do_out, do_rise, do_fall, glitch_cnt);
         end
      end
      rst = 1'b0;
      for (int k = 1; k <= LAT + 1; k++) begin
         tick();
         checks++;
         if (do_out !== (k >= LAT) || do_rise !== (k == LAT) || do_fall !== 1'b0) begin
            errors++;
            $display("FAIL reset_release t%0d got do=%b rise=%b fall=%b exp do=%b rise=%b fall=0",
                     k, do_out, do_rise, do_fall, k >= LAT, k == LAT);
         end
      end
   endtask

   task automatic test_clean();
      do_reset();
      raw_in = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         checks++;
         if (do_out !== (k >= LAT) || do_rise !== (k == LAT) || do_fall !== 1'b0) begin
            errors++;
            $display("FAIL clean_rise t%0d got do=%b rise=%b fall=%b exp do=%b rise=%b fall=0",
                     k, do_out, do_rise, do_fall, k >= LAT, k == LAT);
         end
      end
      raw_in = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         checks++;
         if (do_out !== (k < LAT) || do_fall !== (k == LAT) || do_rise !== 1'b0) begin
            errors++;
            $display("FAIL clean_fall t%0d got do=%b rise=%b fall=%b exp do=%b rise=0 fall=%b",
                     k, do_out, do_rise, do_fall, k < LAT, k == LAT);
         end
      end
      checks++;
      if (glitch_cnt !== 8'd0) begin
         errors++;
         $display("FAIL clean_glitch got %0d exp 0", glitch_cnt);
      end
   endtask

   task automatic test_bounce();
      logic [6:0] pat;
      int         rises;
      pat   = 7'b1111011;
      rises = 0;
      do_reset();
      for (int k = 0; k < 7 + LAT - 4; k++) begin
         raw_in = (k < 7) ? pat[k] : 1'b1;
         tick();
         if (do_rise) rises++;
         checks++;
         if (do_out !== (k == 6 + LAT - 4)) begin
            errors++;
            $display("FAIL bounce_do t%0d got %b exp %b", k + 1, do_out, k == 6 + LAT - 4);
         end
      end
      tick();
      checks++;
      if (glitch_cnt !== 8'd1 || rises != 1 || do_out !== 1'b1) begin
         errors++;
         $display("FAIL bounce_end got glitch=%0d rises=%0d do=%b exp glitch=1 rises=1 do=1",
                  glitch_cnt, rises, do_out);
      end
   endtask

   task automatic test_fall_glitch();
      int falls;
      falls = 0;
      do_reset();
      raw_in = 1'b1;
      repeat (LAT + 1) tick();
      raw_in = 1'b0;
      tick();
      raw_in = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (do_fall) falls++;
         checks++;
         if (do_out !== 1'b1) begin
            errors++;
            $display("FAIL fall_glitch_do t%0d got %b exp 1", k, do_out);
         end
      end
      checks++;
      if (falls != 0 || glitch_cnt !== 8'd1) begin
         errors++;
         $display("FAIL fall_glitch_end got falls=%0d glitch=%0d exp falls=0 glitch=1",
                  falls, glitch_cnt);
      end
   endtask

   task automatic test_saturation();
      int exp_sat;
      do_reset();
      for (int p = 1; p <= 5; p++) begin
         raw_in = 1'b1;
         tick();
         tick();
         raw_in = 1'b0;
         tick();
         tick();
         tick();
         exp_sat = (p > 3) ? 3 : p;
         checks++;
         if (sat_glitch !== 2'(exp_sat) || glitch_cnt !== 8'(p)) begin
            errors++;
            $display("FAIL sat_pulse%0d got sat=%0d wide=%0d exp sat=%0d wide=%0d",
                     p, sat_glitch, glitch_cnt, exp_sat, p);
         end
         checks++;
         if ({sat_do, sat_rise, sat_fall, do_out} !== 4'b0000) begin
            errors++;
            $display("FAIL sat_do_low pulse%0d got %b%b%b%b exp 0000",
                     p, sat_do, sat_rise, sat_fall, do_out);
         end
      end
   endtask

   task automatic test_reset_mid_high();
      do_reset();
      raw_in = 1'b1;
      tick();
      raw_in = 1'b0;
      tick();
      raw_in = 1'b1;
      repeat (LAT + 2) tick();
      checks++;
      if (do_out !== 1'b1 || glitch_cnt !== 8'd1) begin
         errors++;
         $display("FAIL mid_high_pre got do=%b glitch=%0d exp do=1 glitch=1", do_out, glitch_cnt);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (do_out !== 1'b0 || do_fall !== 1'b0 || do_rise !== 1'b0 || glitch_cnt !== 8'd0) begin
         errors++;
         $display("FAIL mid_high_rst got do=%b fall=%b rise=%b glitch=%0d exp 0 0 0 0",
                  do_out, do_fall, do_rise, glitch_cnt);
      end
      for (int k = 1; k <= LAT + 1; k++) begin
         tick();
         checks++;
         if (do_out !== (k >= LAT) || do_rise !== (k == LAT) || do_fall !== 1'b0) begin
            errors++;
            $display("FAIL mid_high_rerise t%0d got do=%b rise=%b fall=%b exp do=%b rise=%b fall=0",
                     k, do_out, do_rise, do_fall, k >= LAT, k == LAT);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      raw_in = 1'b0;
      test_reset();
      test_clean();
      test_bounce();
      test_fall_glitch();
      test_saturation();
      test_reset_mid_high();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/do_debounce.md
Name: do_debounce

Overview:
- Upstream conditioning stage for the onstate_1 FSM.
- Turns a noisy or bouncing raw request line into the clean, registered "do" level that onstate_1 consumes.
- Also emits single-cycle edge strobes and a saturating glitch counter for debug.
- Sits between a pad, switch or asynchronous source and the FSM's "do" input.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable samples required before "do" changes. Legal range 2..255.
- GLITCH_W, 8: width of the glitch counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- raw_in  input  1  raw request level
- do  output  1  debounced level; drives onstate_1 "do"
- do_rise  output  1  one-cycle strobe on the cycle "do" goes 0->1
- do_fall  output  1  one-cycle strobe on the cycle "do" goes 1->0
- glitch_cnt  output  GLITCH_W  count of aborted transitions, saturating

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high; rst sampled high at a clk edge forces the reset state, no async path.
  - Reset state: state=LOW, do=0, do_rise=0, do_fall=0, glitch_cnt=0, internal counter=0, sync flops=0.
- s_in is the FSM's sampled input: raw_in directly, or synchronised (see Optional Feature).
- Internal counter cnt is $clog2(DEBOUNCE_CYCLES+1) bits wide.
- All outputs are registered.
- LOW (do=0):
  - s_in=1 -> RISE_CHK, cnt<=1.
  - s_in=0 -> stay.
- RISE_CHK (do=0):
  - s_in=0 -> LOW, cnt<=0, glitch_cnt++.
  - s_in=1 and cnt==DEBOUNCE_CYCLES-1 -> HIGH, do<=1, do_rise<=1, cnt<=0.
  - Otherwise cnt++.
- HIGH (do=1):
  - s_in=0 -> FALL_CHK, cnt<=1.
  - s_in=1 -> stay.
- FALL_CHK (do=1):
  - s_in=1 -> HIGH, cnt<=0, glitch_cnt++.
  - s_in=0 and cnt==DEBOUNCE_CYCLES-1 -> LOW, do<=0, do_fall<=1, cnt<=0.
  - Otherwise cnt++.
- Latency: s_in stable for N=DEBOUNCE_CYCLES consecutive edges -> "do" updates at the Nth edge, visible in the following cycle.
- Strobes are high for exactly one cycle and never both high together. Default 0.
- Glitch counter:
  - Saturates at all-ones; never wraps.
  - Increments only on an aborted CHK state, i.e. a return to the state it came from.
- A single-cycle opposite sample inside a CHK state fully restarts qualification. There is no partial credit.
- Reset mid-operation (any state, including HIGH or FALL_CHK):
  - Returns to LOW with do=0.
  - No do_fall strobe is emitted.
  - glitch_cnt clears.
- No other inputs; the block always runs.

Optional Feature:
- Macro: DO_DEBOUNCE_SYNC_EN.
- Defined:
  - raw_in passes through a two-flop synchroniser: s_in = sync2 output.
  - Total rise/fall latency is DEBOUNCE_CYCLES+2 edges.
  - The sync flops reset to 0.
- Undefined:
  - s_in = raw_in.
  - raw_in must already be synchronous to clk.
  - Latency is DEBOUNCE_CYCLES edges.

Test Plan (DEBOUNCE_CYCLES=4, macro undefined unless stated):
- Reset: rst=1 for 2 cycles, raw_in=1 -> do=0, strobes=0, glitch_cnt=0 throughout reset; 4 cycles after rst drops, do=1 with a single do_rise.
- Clean rise/fall: raw_in 0->1 held 10 cycles, then 0 held 10 cycles -> do=1 starting 4 cycles after the rise, one do_rise; do=0 4 cycles after the fall, one do_fall; glitch_cnt=0.
- Bounce: raw_in pattern 1,1,0,1,1,1,1 -> one glitch (glitch_cnt=1); do rises after the final four 1s; exactly one do_rise.
- Saturation (GLITCH_W=2): five 2-cycle pulses of raw_in=1 separated by 0s -> glitch_cnt reaches 3 and holds; do stays 0.
- Reset mid-HIGH: do=1, assert rst one cycle -> do=0 next cycle, no do_fall, state LOW; raw_in still 1 -> do re-rises after 4 cycles.
- DO_DEBOUNCE_SYNC_EN defined: clean 0->1 step -> do rises 6 edges after the step; drives onstate_1 so that "f" responds as in its own bench.
